// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle shared by the round-robin arbiter and its requesters.
interface rr_arbiter_8_if;
    logic       enable;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output enable, req,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  enable, req,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Winner is presented as index and one-hot vector; all outputs registered.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input logic           clk,
    input logic           reset_n,
    rr_arbiter_8_if.slave arb
);

    localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    // Bit 3 flags a winner; search starts just after the last owner.
    function automatic logic [3:0] pick(input logic [7:0] r,
                                        input logic [2:0] l);
        logic [3:0] res;
        logic [2:0] j;
        res = '0;
        for (int i = 1; i <= 8; i++) begin
            j = l + 3'(i);
            if (!res[3] && r[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    logic       own_req;
    logic       forced;
    logic       rel;
    logic [3:0] win_idle;
    logic [3:0] win_rel;

    assign own_req  = arb.req[idx_q];
    assign forced   = own_req && (cnt_q == CMAX);
    assign rel      = !own_req || forced;
    assign win_idle = pick(arb.req, last_q);
    assign win_rel  = pick(arb.req & ~(8'b1 << idx_q), last_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (arb.enable && win_idle[3]) begin
                    state_d = S_GRANT;
                    idx_d   = win_idle[2:0];
                    last_d  = win_idle[2:0];
                    gnt_d   = 8'b1 << win_idle[2:0];
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (rel) begin
                    to_d = forced;
                    if (arb.enable && win_rel[3]) begin
                        idx_d  = win_rel[2:0];
                        last_d = win_rel[2:0];
                        gnt_d  = 8'b1 << win_rel[2:0];
                        cnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 3'd7;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = idx_q;
    assign arb.gnt_valid = (state_q == S_GRANT);
    assign arb.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed checks of rr_arbiter_8 at hold limits 16, 4, 2 and 1.
module tb_rr_arbiter_8;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_a;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    rr_arbiter_8_if ia ();
    rr_arbiter_8_if ib ();
    rr_arbiter_8_if ic ();
    rr_arbiter_8_if id ();

    rr_arbiter_8 #(.HOLD_MAX(16)) u_a (.clk(clk), .reset_n(rst_a), .arb(ia));
    rr_arbiter_8 #(.HOLD_MAX(4))  u_b (.clk(clk), .reset_n(rst_n), .arb(ib));
    rr_arbiter_8 #(.HOLD_MAX(2))  u_c (.clk(clk), .reset_n(rst_n), .arb(ic));
    rr_arbiter_8 #(.HOLD_MAX(1))  u_d (.clk(clk), .reset_n(rst_n), .arb(id));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] g,
                         input logic [2:0] ix, input logic v,
                         input logic t);
        chk({tag, ".gnt"}, 32'(ia.gnt), 32'(g));
        chk({tag, ".idx"}, 32'(ia.gnt_idx), 32'(ix));
        chk({tag, ".vld"}, 32'(ia.gnt_valid), 32'(v));
        chk({tag, ".to"}, 32'(ia.timeout), 32'(t));
    endtask

    initial begin
        rst_n = 1'b0;
        rst_a = 1'b0;
        ia.enable = 1'b0; ia.req = '0;
        ib.enable = 1'b0; ib.req = '0;
        ic.enable = 1'b0; ic.req = '0;
        id.enable = 1'b0; id.req = '0;
        #3;
        chk_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset_b.gnt", 32'(ib.gnt), 32'h0);
        #4;
        rst_n = 1'b1;
        rst_a = 1'b1;

        // single requester 0, then drop
        ia.enable = 1'b1;
        ia.req = 8'h01;
        step();
        chk_a("grant0", 8'h01, 3'd0, 1'b1, 1'b0);
        ia.req = 8'h00;
        step();
        chk_a("drop0", 8'h00, 3'd0, 1'b0, 1'b0);

        // owner 5, then handover to 2 with no idle gap
        ia.req = 8'h20;
        step();
        chk_a("grant5", 8'h20, 3'd5, 1'b1, 1'b0);
        ia.req = 8'h24;
        step();
        chk_a("hold5", 8'h20, 3'd5, 1'b1, 1'b0);
        ia.req = 8'h04;
        step();
        chk_a("hand2", 8'h04, 3'd2, 1'b1, 1'b0);
        ia.req = 8'h00;
        step();
        chk_a("idle2", 8'h00, 3'd2, 1'b0, 1'b0);

        // enable gating
        ia.enable = 1'b0;
        ia.req = 8'h80;
        step();
        chk_a("en0a", 8'h00, 3'd2, 1'b0, 1'b0);
        step();
        chk_a("en0b", 8'h00, 3'd2, 1'b0, 1'b0);
        ia.enable = 1'b1;
        step();
        chk_a("en1", 8'h80, 3'd7, 1'b1, 1'b0);
        ia.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a("en_drop_hold", 8'h80, 3'd7, 1'b1, 1'b0);
        end
        ia.req = 8'h00;
        step();
        chk_a("en_rel", 8'h00, 3'd7, 1'b0, 1'b0);
        ia.req = 8'h01;
        step();
        chk_a("en_off_idle", 8'h00, 3'd7, 1'b0, 1'b0);

        // async reset during grant of index 6
        ia.enable = 1'b1;
        ia.req = 8'h40;
        step();
        chk_a("grant6", 8'h40, 3'd6, 1'b1, 1'b0);
        #2;
        rst_a = 1'b0;
        #1;
        chk_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_a("in_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_a = 1'b1;
        step();
        chk_a("regrant6", 8'h40, 3'd6, 1'b1, 1'b0);
        ia.req = 8'h00;

        // HOLD_MAX=4, all requesting: 4-cycle turns, 0..7 then 0
        ib.enable = 1'b1;
        ib.req = 8'hFF;
        for (int n = 1; n <= 36; n++) begin
            int o;
            o = ((n - 1) / 4) % 8;
            step();
            chk("rot.gnt", 32'(ib.gnt), 32'(1) << o);
            chk("rot.idx", 32'(ib.gnt_idx), 32'(o));
            chk("rot.vld", 32'(ib.gnt_valid), 32'h1);
            chk("rot.to", 32'(ib.timeout),
                32'((n > 1) && ((n - 1) % 4 == 0)));
        end
        ib.req = 8'h00;
        step();
        chk("rot_end.gnt", 32'(ib.gnt), 32'h0);
        chk("rot_end.to", 32'(ib.timeout), 32'h0);

        // HOLD_MAX=2, lone requester 3: 2 on, 1 idle with timeout
        ic.enable = 1'b1;
        ic.req = 8'h08;
        for (int n = 1; n <= 6; n++) begin
            logic [7:0] eg;
            logic       et;
            eg = (n % 3 == 0) ? 8'h00 : 8'h08;
            et = (n % 3 == 0);
            step();
            chk("h2.gnt", 32'(ic.gnt), 32'(eg));
            chk("h2.to", 32'(ic.timeout), 32'(et));
            chk("h2.idx", 32'(ic.gnt_idx), 32'd3);
        end
        ic.req = 8'h00;

        // HOLD_MAX=1, requesters 0 and 1 alternate every cycle
        id.enable = 1'b1;
        id.req = 8'h03;
        for (int n = 1; n <= 5; n++) begin
            logic [2:0] ei;
            ei = (n % 2 == 1) ? 3'd0 : 3'd1;
            step();
            chk("h1.gnt", 32'(id.gnt), 32'(8'h01 << ei));
            chk("h1.idx", 32'(id.gnt_idx), 32'(ei));
            chk("h1.to", 32'(id.timeout), 32'(n > 1));
        end
        id.req = 8'h00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
